// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text engine.
package lcd_pkg;

  localparam int unsigned LCD_COL_W = 7;
  localparam logic [7:0]  SPACE_CHAR = 8'h20;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StReq,
    StRel
  } lcd_state_e;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// Character store: PAGES x ROWS x COLS bytes, one write port, one async read port,
// every cell reset to a space.
module lcd_char_ram
  import lcd_pkg::*;
#(
  parameter int unsigned PAGES  = 2,
  parameter int unsigned ROWS   = 2,
  parameter int unsigned COLS   = 16,
  parameter int unsigned PAGE_W = 1,
  parameter int unsigned ROW_W  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [PAGE_W-1:0]    wr_page_i,
  input  logic [ROW_W-1:0]     wr_row_i,
  input  logic [LCD_COL_W-1:0] wr_col_i,
  input  logic [7:0]           wr_data_i,
  input  logic [PAGE_W-1:0]    rd_page_i,
  input  logic [ROW_W-1:0]     rd_row_i,
  input  logic [LCD_COL_W-1:0] rd_col_i,
  output logic [7:0]           rd_data_o
);

  localparam int unsigned DEPTH  = PAGES * ROWS * COLS;
  localparam int unsigned ADDR_W = clog2_min1(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  int unsigned wr_idx;
  int unsigned rd_idx;

  function automatic int unsigned cell_idx(input logic [PAGE_W-1:0]    p,
                                           input logic [ROW_W-1:0]     r,
                                           input logic [LCD_COL_W-1:0] c);
    return (32'(p) * ROWS + 32'(r)) * COLS + 32'(c);
  endfunction

  assign wr_idx = cell_idx(wr_page_i, wr_row_i, wr_col_i);
  assign rd_idx = cell_idx(rd_page_i, rd_row_i, rd_col_i);

  // Out-of-range read (non power-of-two page count) shows a blank cell.
  assign rd_data_o = (rd_idx < DEPTH) ? mem_q[ADDR_W'(rd_idx)] : SPACE_CHAR;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[ADDR_W'(i)] <= SPACE_CHAR;
      end
    end else if (we_i && (wr_idx < DEPTH)) begin
      mem_q[ADDR_W'(wr_idx)] <= wr_data_i;
    end
  end

endmodule

// File: rtl/lcd_text_engine.sv
// Multi-page text frame buffer with an on-demand refresh sequencer that streams the
// selected page to the LCD driver over a four-phase rq/ack handshake.
module lcd_text_engine
  import lcd_pkg::*;
#(
  parameter int unsigned ROWS   = 2,
  parameter int unsigned COLS   = 16,
  parameter int unsigned PAGES  = 2,
  parameter int unsigned ROW_W  = clog2_min1(ROWS),
  parameter int unsigned PAGE_W = clog2_min1(PAGES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PAGE_W-1:0]    page_sel,
  input  logic                 blank,
  input  logic                 refresh,
  input  logic                 wr_en,
  input  logic [PAGE_W-1:0]    wr_page,
  input  logic [ROW_W-1:0]     wr_row,
  input  logic [LCD_COL_W-1:0] wr_col,
  input  logic [7:0]           wr_char,
  output logic                 rq,
  input  logic                 ack,
  output logic [ROW_W-1:0]     lcd_row,
  output logic [LCD_COL_W-1:0] lcd_column,
  output logic [7:0]           lcd_character,
  output logic                 busy,
  output logic                 frame_done
);

  lcd_state_e           state_q, state_d;
  logic [PAGE_W-1:0]    act_page_q, act_page_d;
  logic                 act_blank_q, act_blank_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [LCD_COL_W-1:0] col_q, col_d;
  logic                 pending_q, pending_d;
  logic                 rq_q, rq_d;
  logic [ROW_W-1:0]     lcd_row_q, lcd_row_d;
  logic [LCD_COL_W-1:0] lcd_col_q, lcd_col_d;
  logic [7:0]           lcd_char_q, lcd_char_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;

  logic       start;
  logic       wr_ok;
  logic       last_col;
  logic       last_row;
  logic [7:0] rd_data;

  assign wr_ok = wr_en && (32'(wr_page) < PAGES) && (32'(wr_row) < ROWS)
                 && (32'(wr_col) < COLS);
  assign last_col = (32'(col_q) == COLS - 1);
  assign last_row = (32'(row_q) == ROWS - 1);

  lcd_char_ram #(
    .PAGES  (PAGES),
    .ROWS   (ROWS),
    .COLS   (COLS),
    .PAGE_W (PAGE_W),
    .ROW_W  (ROW_W)
  ) u_char_ram (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .we_i      (wr_ok),
    .wr_page_i (wr_page),
    .wr_row_i  (wr_row),
    .wr_col_i  (wr_col),
    .wr_data_i (wr_char),
    .rd_page_i (act_page_q),
    .rd_row_i  (row_q),
    .rd_col_i  (col_q),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    act_page_d   = act_page_q;
    act_blank_d  = act_blank_q;
    row_d        = row_q;
    col_d        = col_q;
    rq_d         = rq_q;
    lcd_row_d    = lcd_row_q;
    lcd_col_d    = lcd_col_q;
    lcd_char_d   = lcd_char_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    start        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          act_page_d  = page_sel;
          act_blank_d = blank;
          row_d       = '0;
          col_d       = '0;
          busy_d      = 1'b1;
          start       = 1'b1;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        lcd_row_d  = row_q;
        lcd_col_d  = col_q;
        lcd_char_d = act_blank_q ? SPACE_CHAR : rd_data;
        rq_d       = 1'b1;
        state_d    = StReq;
      end
      StReq: begin
        if (ack) begin
          rq_d    = 1'b0;
          state_d = StRel;
        end
      end
      StRel: begin
        if (!ack) begin
          if (last_col && last_row) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = StIdle;
          end else begin
            if (last_col) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + LCD_COL_W'(1);
            end
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Compare against the values the frame will use, so a frame start clears its own trigger.
    pending_d = (pending_q && !start) || refresh
                || (page_sel != act_page_d) || (blank != act_blank_d)
                || (wr_ok && (wr_page == act_page_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      act_page_q   <= '0;
      act_blank_q  <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      pending_q    <= 1'b1;
      rq_q         <= 1'b0;
      lcd_row_q    <= '0;
      lcd_col_q    <= '0;
      lcd_char_q   <= SPACE_CHAR;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_page_q   <= act_page_d;
      act_blank_q  <= act_blank_d;
      row_q        <= row_d;
      col_q        <= col_d;
      pending_q    <= pending_d;
      rq_q         <= rq_d;
      lcd_row_q    <= lcd_row_d;
      lcd_col_q    <= lcd_col_d;
      lcd_char_q   <= lcd_char_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rq            = rq_q;
  assign lcd_row       = lcd_row_q;
  assign lcd_column    = lcd_col_q;
  assign lcd_character = lcd_char_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_lcd_text_engine.sv
// Bench for lcd_text_engine: directed scenarios plus randomized writes/page/blank changes,
// checked against a cell-array model of what the display should show.
module tb_lcd_text_engine;

  localparam int ROWS   = 2;
  localparam int COLS   = 16;
  localparam int PAGES  = 2;
  localparam int ROW_W  = 1;
  localparam int PAGE_W = 1;
  localparam int CELLS  = ROWS * COLS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PAGE_W-1:0] page_sel;
  logic              blank;
  logic              refresh;
  logic              wr_en;
  logic [PAGE_W-1:0] wr_page;
  logic [ROW_W-1:0]  wr_row;
  logic [6:0]        wr_col;
  logic [7:0]        wr_char;
  logic              rq;
  logic              ack;
  logic [ROW_W-1:0]  lcd_row;
  logic [6:0]        lcd_column;
  logic [7:0]        lcd_character;
  logic              busy;
  logic              frame_done;

  always #10 clk = ~clk;

  lcd_text_engine #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .PAGES (PAGES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .page_sel      (page_sel),
    .blank         (blank),
    .refresh       (refresh),
    .wr_en         (wr_en),
    .wr_page       (wr_page),
    .wr_row        (wr_row),
    .wr_col        (wr_col),
    .wr_char       (wr_char),
    .rq            (rq),
    .ack           (ack),
    .lcd_row       (lcd_row),
    .lcd_column    (lcd_column),
    .lcd_character (lcd_character),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  typedef struct packed {
    logic [7:0] row;
    logic [6:0] col;
    logic [7:0] ch;
  } req_t;

  req_t       req_q[$];
  int         n_frames  = 0;
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         ack_delay = 3;
  int         ack_hold  = 1;
  bit         resp_en   = 1'b1;
  logic [7:0] mdl [PAGES][ROWS][COLS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mdl_reset();
    foreach (mdl[p, r, c]) mdl[p][r][c] = 8'h20;
  endtask

  task automatic wr(input int p, input int r, input int c, input logic [7:0] ch);
    wr_en   = 1'b1;
    wr_page = PAGE_W'(p);
    wr_row  = ROW_W'(r);
    wr_col  = 7'(c);
    wr_char = ch;
    tick(1);
    wr_en = 1'b0;
    if (p < PAGES && r < ROWS && c < COLS) mdl[p][r][c] = ch;
  endtask

  // Wait until the engine has been idle (no busy, no rq) for 40 consecutive cycles.
  task automatic quiesce();
    int quiet = 0;
    int n = 0;
    while (quiet < 40 && n < 8000) begin
      tick(1);
      n++;
      if (!busy && !rq) quiet++;
      else quiet = 0;
    end
    check_eq("quiesce", quiet, 40);
  endtask

  task automatic wait_reqs(input int target);
    for (int n = 0; n < 2000 && req_q.size() < target; n++) tick(1);
    check_eq("wait_reqs", req_q.size() >= target, 1);
  endtask

  // Exact row-major frame starting at request index base.
  task automatic check_frame(input int base, input int p, input bit b);
    req_t e;
    int   r;
    int   c;
    for (int i = 0; i < CELLS; i++) begin
      if (base + i >= req_q.size()) begin
        check_eq("frame_short", req_q.size() - base, CELLS);
        return;
      end
      r = i / COLS;
      c = i % COLS;
      e = req_q[base + i];
      check_eq("frame_row", e.row, r);
      check_eq("frame_col", e.col, c);
      check_eq("frame_char", e.ch, b ? 8'h20 : mdl[p][r][c]);
    end
  endtask

  // Final screen contents after all requests since base, regardless of frame count.
  task automatic check_screen(input int base, input int p, input bit b);
    logic [7:0] scr [ROWS][COLS];
    foreach (scr[r, c]) scr[r][c] = 8'h00;
    for (int i = base; i < req_q.size(); i++) begin
      if (int'(req_q[i].row) < ROWS && int'(req_q[i].col) < COLS)
        scr[int'(req_q[i].row)][int'(req_q[i].col)] = req_q[i].ch;
    end
    foreach (scr[r, c])
      check_eq($sformatf("screen_p%0d_r%0d_c%0d", p, r, c), scr[r][c],
               b ? 8'h20 : mdl[p][r][c]);
  endtask

  // Four-phase responder: ack after ack_delay cycles, held for ack_hold cycles.
  initial begin
    ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rq && resp_en) begin
        repeat (ack_delay) begin
          @(posedge clk);
          #1;
        end
        ack = 1'b1;
        repeat (ack_hold) begin
          @(posedge clk);
          #1;
        end
        ack = 1'b0;
      end
    end
  end

  // Protocol monitor: captures each request and checks handshake rules.
  logic rq_prev  = 1'b0;
  logic ack_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      rq_prev  = 1'b0;
      ack_prev = 1'b0;
    end else begin
      if (rq && !rq_prev) begin
        check_eq("rq_rise_ack_low", ack_prev, 0);
        req_q.push_back('{row: 8'(lcd_row), col: lcd_column, ch: lcd_character});
      end
      if (rq_prev && ack_prev) check_eq("rq_drop_after_ack", rq, 0);
      else if (rq && rq_prev)
        check_eq("rq_hold_stable", {8'(lcd_row), lcd_column, lcd_character}, req_q[$]);
      if (frame_done) begin
        n_frames++;
        check_eq("frame_done_busy", busy, 0);
      end
      rq_prev  = rq;
      ack_prev = ack;
    end
  end

  initial begin
    int         base;
    int         fb;
    int         sh_page;
    bit         sh_blank;
    bit         exp_redraw;
    int         np;
    int         nw;
    int         p;
    int         c;
    bit         nb;
    bit         rf;
    logic [7:0] hello [5];

    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    rst_n = 1'b0; page_sel = '0; blank = 1'b0; refresh = 1'b0;
    wr_en = 1'b0; wr_page = '0; wr_row = '0; wr_col = '0; wr_char = '0;
    mdl_reset();
    tick(3);
    check_eq("rst_rq", rq, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_char", lcd_character, 8'h20);
    check_eq("rst_row", lcd_row, 0);
    check_eq("rst_col", lcd_column, 0);

    // Boot frame of spaces.
    base = req_q.size(); fb = n_frames;
    rst_n = 1'b1;
    quiesce();
    check_eq("boot_frames", n_frames - fb, 1);
    check_eq("boot_reqs", req_q.size() - base, CELLS);
    check_frame(base, 0, 0);
    check_eq("boot_busy_after", busy, 0);

    // HELLO into the shown page.
    base = req_q.size(); fb = n_frames;
    for (int i = 0; i < 5; i++) wr(0, 1, i, hello[i]);
    quiesce();
    check_eq("hello_redraw", (n_frames - fb) >= 1, 1);
    check_screen(base, 0, 0);

    // Hidden page writes must not redraw; switching page shows them.
    base = req_q.size();
    for (int i = 0; i < 3; i++) wr(1, 0, i, 8'($urandom_range(65, 90)));
    quiesce();
    check_eq("hidden_wr_reqs", req_q.size() - base, 0);
    base = req_q.size(); fb = n_frames;
    page_sel = 1'b1;
    quiesce();
    check_eq("page1_frames", n_frames - fb, 1);
    check_frame(base, 1, 0);

    // Blank toggled mid-frame: frame finishes unblanked, next one is blank.
    base = req_q.size(); fb = n_frames;
    page_sel = 1'b0;
    wait_reqs(base + 5);
    blank = 1'b1;
    quiesce();
    check_eq("blank_frames", n_frames - fb, 2);
    check_frame(base, 0, 0);
    check_frame(base + CELLS, 0, 1);

    // Long ack hold via refresh.
    ack_hold = 5;
    base = req_q.size(); fb = n_frames;
    refresh = 1'b1;
    tick(1);
    refresh = 1'b0;
    quiesce();
    check_eq("hold_frames", n_frames - fb, 1);
    check_frame(base, 0, 1);
    ack_hold = 1;

    // Out-of-range column write is ignored.
    base = req_q.size();
    wr(0, 0, 100, 8'h41);
    quiesce();
    check_eq("oor_col_reqs", req_q.size() - base, 0);

    blank = 1'b0;
    quiesce();

    // Reset while a request is outstanding.
    resp_en = 1'b0;
    refresh = 1'b1;
    tick(1);
    refresh = 1'b0;
    for (int n = 0; n < 50 && !rq; n++) tick(1);
    check_eq("rq_before_reset", rq, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_rq", rq, 0);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_char", lcd_character, 8'h20);
    tick(2);
    mdl_reset();
    resp_en = 1'b1;
    base = req_q.size(); fb = n_frames;
    rst_n = 1'b1;
    quiesce();
    check_eq("post_rst_frames", n_frames - fb, 1);
    check_frame(base, 0, 0);

    // Randomized writes, page and blank changes.
    sh_page = 0; sh_blank = 1'b0;
    for (int it = 0; it < 25; it++) begin
      base = req_q.size(); fb = n_frames;
      exp_redraw = 1'b0;
      ack_delay = $urandom_range(0, 3);
      nw = $urandom_range(0, 4);
      for (int k = 0; k < nw; k++) begin
        p = $urandom_range(0, PAGES - 1);
        c = ($urandom_range(0, 3) == 0) ? $urandom_range(COLS, 127) : $urandom_range(0, COLS - 1);
        if (p == sh_page && c < COLS) exp_redraw = 1'b1;
        wr(p, $urandom_range(0, ROWS - 1), c, 8'($urandom_range(32, 126)));
        tick($urandom_range(0, 2));
      end
      np = $urandom_range(0, PAGES - 1);
      nb = 1'($urandom_range(0, 1));
      rf = ($urandom_range(0, 3) == 0);
      if (np != sh_page || nb != sh_blank || rf) exp_redraw = 1'b1;
      page_sel = PAGE_W'(np);
      blank    = nb;
      refresh  = rf;
      tick(1);
      refresh = 1'b0;
      quiesce();
      if (exp_redraw) begin
        check_eq("rand_redraw", (n_frames - fb) >= 1, 1);
        check_screen(base, np, nb);
      end else begin
        check_eq("rand_no_redraw", req_q.size() - base, 0);
      end
      sh_page  = np;
      sh_blank = nb;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
